// File: rtl/fp16_square_pkg.sv
// Shared FP16 constants, operand classes and helpers for the multi-cycle FP16 units.
package fp16_square_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;
  localparam int SIG_W      = FP16_MAN_W + 1;
  localparam int PROD_W     = 2 * SIG_W;

  localparam logic [15:0] FP16_QNAN  = 16'h7E00;
  localparam logic [15:0] FP16_PINF  = 16'h7C00;
  localparam logic [15:0] FP16_PZERO = 16'h0000;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_t;

  // Leading-zero count of an 11-bit significand (11 when all zero).
  function automatic logic [3:0] fp16_lzc11(input logic [10:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd11;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(10 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_sq_round.sv
// Combinational RNE rounding and packing of (sign, biased exponent, 1.f significand, GRS) into FP16.
// FP16_SQUARE_SUBNORM_EN enables gradual underflow; otherwise exponents <= 0 flush to signed zero.
module fp16_sq_round
  import fp16_square_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [7:0] exp_i,
  input  logic [10:0]       sig_i,
  input  logic [2:0]        grs_i,
  output logic [15:0]       word_o
);

  logic              rnd_up;
  logic [11:0]       sum;
  logic signed [7:0] exp_r;
  logic [9:0]        frac_n;
`ifdef FP16_SQUARE_SUBNORM_EN
  logic signed [7:0] sh_full;
  logic [4:0]        sh;
  logic [26:0]       wide;
  logic [10:0]       sig_s;
  logic              g_s;
  logic              s_s;
  logic              rnd_up_s;
  logic [10:0]       sum_s;
`endif

  always_comb begin
    word_o = {sign_i, 15'd0};
    rnd_up = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
    sum    = {1'b0, sig_i} + {11'd0, rnd_up};
    exp_r  = exp_i + (sum[11] ? 8'sd1 : 8'sd0);
    // A carry out of 1.f leaves the fraction all zero.
    frac_n = sum[11] ? sum[10:1] : sum[9:0];
`ifdef FP16_SQUARE_SUBNORM_EN
    sh_full  = 8'sd1 - exp_i;
    sh       = (sh_full > 8'sd14) ? 5'd14 : sh_full[4:0];
    wide     = {sig_i, grs_i[2], grs_i[1], 14'd0} >> sh;
    sig_s    = wide[26:16];
    g_s      = wide[15];
    s_s      = (|wide[14:0]) | grs_i[0];
    rnd_up_s = g_s & (s_s | sig_s[0]);
    sum_s    = sig_s + {10'd0, rnd_up_s};
`endif
    if (exp_i > 8'sd0) begin
      if (exp_r >= 8'sd31) word_o = {sign_i, FP16_PINF[14:0]};
      else                 word_o = {sign_i, exp_r[4:0], frac_n};
    end else begin
`ifdef FP16_SQUARE_SUBNORM_EN
      // Rounding up to 1024 lands exactly on the smallest normal encoding.
      word_o = {sign_i, 4'd0, sum_s[10], sum_s[9:0]};
`else
      word_o = {sign_i, 15'd0};
`endif
    end
  end

endmodule

// File: rtl/fp16_square.sv
// Multi-cycle FP16 squarer (result = a*a) with shift-add significand multiply and valid/ready handshakes.
// FP16_SQUARE_SUBNORM_EN enables subnormal inputs/outputs; default build flushes them to zero.
module fp16_square
  import fp16_square_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_PACK   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       a_q, a_d;
  fp_cls_t           cls_q, cls_d;
  logic [10:0]       sig_q, sig_d;
  logic signed [7:0] ea_q, ea_d;
  logic [21:0]       acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic signed [7:0] er_q, er_d;
  logic [10:0]       man_q, man_d;
  logic [2:0]        grs_q, grs_d;

  logic [4:0]        exp_f;
  logic [9:0]        man_f;
  logic [3:0]        lz;
  logic              sq_sign;
  logic [15:0]       rnd_word;

  // Sign of a*a: identical operand signs always cancel.
  assign sq_sign = a_q[15] ^ a_q[15];
  assign exp_f   = a_q[14:10];
  assign man_f   = a_q[9:0];
  assign lz      = fp16_lzc11({1'b0, man_f});

  fp16_sq_round u_round (
    .sign_i (sq_sign),
    .exp_i  (er_q),
    .sig_i  (man_q),
    .grs_i  (grs_q),
    .word_o (rnd_word)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    a_d         = a_q;
    cls_d       = cls_q;
    sig_d       = sig_q;
    ea_d        = ea_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    er_d        = er_q;
    man_d       = man_q;
    grs_d       = grs_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          in_ready_d = 1'b0;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        cls_d = CLS_NORM;
        sig_d = {1'b1, man_f};
        ea_d  = $signed({3'd0, exp_f}) - 8'(FP16_BIAS);
        if (exp_f == 5'h1F) begin
          cls_d = (man_f != 10'd0) ? CLS_NAN : CLS_INF;
          sig_d = 11'd0;
          ea_d  = 8'sd0;
        end else if (exp_f == 5'd0) begin
          cls_d = CLS_ZERO;
          sig_d = 11'd0;
          ea_d  = 8'sd0;
`ifdef FP16_SQUARE_SUBNORM_EN
          if (man_f != 10'd0) begin
            cls_d = CLS_NORM;
            sig_d = {1'b0, man_f} << lz;
            ea_d  = -8'sd14 - $signed({4'd0, lz});
          end
`endif
        end
        acc_d   = 22'd0;
        cnt_d   = 4'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (sig_q[cnt_q]) acc_d = acc_q + (22'(sig_q) << cnt_q);
        if (cnt_q == 4'd10) state_d = S_NORM;
        else                cnt_d   = cnt_q + 4'd1;
      end
      S_NORM: begin
        // Product is in [1,4); a set top bit means one extra exponent step.
        if (acc_q[21]) begin
          man_d = acc_q[21:11];
          grs_d = {acc_q[10], acc_q[9], |acc_q[8:0]};
        end else begin
          man_d = acc_q[20:10];
          grs_d = {acc_q[9], acc_q[8], |acc_q[7:0]};
        end
        er_d    = (ea_q <<< 1) + (acc_q[21] ? 8'sd16 : 8'sd15);
        state_d = S_PACK;
      end
      S_PACK: begin
        case (cls_q)
          CLS_NAN:  res_d = FP16_QNAN;
          CLS_INF:  res_d = FP16_PINF;
          CLS_ZERO: res_d = FP16_PZERO;
          default:  res_d = rnd_word;
        endcase
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= FP16_PZERO;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
    a_q   <= a_d;
    cls_q <= cls_d;
    sig_q <= sig_d;
    ea_q  <= ea_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
    er_q  <= er_d;
    man_q <= man_d;
    grs_q <= grs_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;

endmodule

// File: tb/tb_fp16_square.sv
// Self-checking bench for fp16_square: directed cases, handshake/reset scenarios and random operands
// compared with an exact-arithmetic FP16 squaring model.
module tb_fp16_square;

`ifdef FP16_SQUARE_SUBNORM_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_square dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Exact square: value = m * 2^e2, then rounded to the nearest FP16 quantum (ties to even).
  function automatic logic [15:0] ref_sq(input logic [15:0] x);
    int     ef, e2, p, ee, q, sh;
    longint man, sig, m, mq, rem, half;
    ef  = int'(x[14:10]);
    man = longint'(x[9:0]);
    if (ef == 31) return (man != 0) ? 16'h7E00 : 16'h7C00;
    if (ef == 0 && man == 0) return 16'h0000;
    if (ef == 0) begin
      if (!SUBN) return 16'h0000;
      sig = man;
      e2  = -48;
    end else begin
      sig = man + 1024;
      e2  = 2 * (ef - 25);
    end
    m = sig * sig;
    p = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    ee = p + e2;
    if (ee < -14 && !SUBN) return 16'h0000;
    q  = (ee < -14) ? -24 : ee - 10;
    sh = q - e2;
    if (sh > 0) begin
      mq   = m >> sh;
      rem  = m - (mq << sh);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && mq[0])) mq++;
    end else begin
      mq = m << (-sh);
    end
    if (mq >= 2048) begin
      mq = mq >> 1;
      q++;
    end
    if (mq < 1024) return 16'(mq);
    if (q + 25 >= 31) return 16'h7C00;
    return {1'b0, 5'(q + 25), 10'(mq)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] want, input string tag);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check16({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    a        = av;
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_int({tag, "_lat"}, lat, 14);
    check16({tag, "_res"}, result, want);
    tick();
    check16({tag, "_post"}, {14'd0, out_valid, in_ready}, 16'b01);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] ra;
    int          w;
    int          seen;

    out_ready = 1'b1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h4000;
    tick();
    tick();
    tick();
    check16("reset_state", {out_valid, in_ready, 14'd0}, {1'b0, 1'b1, 14'd0});
    check16("reset_result", result, 16'h0000);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();

    do_op(16'h3C00, 16'h3C00, "one");
    do_op(16'h4000, 16'h4400, "two");
    do_op(16'h3E00, 16'h4080, "one_half");
    do_op(16'hC200, 16'h4880, "neg_three");
    do_op(16'h8000, 16'h0000, "neg_zero");
    do_op(16'hFC00, 16'h7C00, "neg_inf");
    do_op(16'h7E01, 16'h7E00, "nan");
    do_op(16'h5C00, 16'h7C00, "overflow");
    do_op(16'h5BFF, ref_sq(16'h5BFF), "near_max");
    do_op(16'h2000, 16'h0400, "min_normal");
    do_op(16'h1C00, SUBN ? 16'h0100 : 16'h0000, "subnormal_out");
    do_op(16'h0001, 16'h0000, "tiny_in");
    do_op(16'h1BFF, ref_sq(16'h1BFF), "underflow_rnd");

    // Backpressure: result held, input ignored while DONE waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 16'h3E00;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    check_int("bp_lat", w, 14);
    held = result;
    check16("bp_res", held, 16'h4080);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a        = 16'($urandom);
      tick();
      check16("bp_hold", {out_valid, in_ready, 14'd0}, {1'b1, 1'b0, 14'd0});
      check16("bp_stable", result, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check16("bp_release", {14'd0, out_valid, in_ready}, 16'b01);

    // Reset in the middle of the multiply.
    in_valid = 1'b1;
    a        = 16'h4200;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check16("midrst_ctl", {out_valid, in_ready, 14'd0}, {1'b0, 1'b1, 14'd0});
    check16("midrst_res", result, 16'h0000);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_int("midrst_no_out", seen, 0);
    do_op(16'h4000, 16'h4400, "after_rst");

    // Random operands spread over all exponents.
    for (int i = 0; i < 40; i++) begin
      ra = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
      do_op(ra, ref_sq(ra), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
